// File: rtl/fp_rf_pkg.sv
// Shared FP register-file definitions: operand formats, legality check, per-port request decode.
// Combinational helpers only; no state.
package fp_rf_pkg;

    localparam logic [4:0] FMT_S = 5'h10;
    localparam logic [4:0] FMT_D = 5'h11;

    typedef struct packed {
        logic legal;
        logic dbl;
    } rd_port_t;

    function automatic logic fmt_legal(input logic [4:0] fmt, input logic addr_lsb);
        return (fmt == FMT_S) || ((fmt == FMT_D) && !addr_lsb);
    endfunction

    function automatic rd_port_t fmt_decode(input logic [4:0] fmt, input logic addr_lsb);
        rd_port_t d;
        d.legal = fmt_legal(fmt, addr_lsb);
        d.dbl   = (fmt == FMT_D);
        return d;
    endfunction

endpackage

// File: rtl/fp_regfile_mp_if.sv
// Bus bundle for the FP register file: N read ports, one WB write port, one issue-reserve port.
// Read results and fmt_err come back registered, one cycle after the request; no backpressure.
interface fp_regfile_mp_if #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 32,
    parameter int NUM_RD   = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [5*NUM_RD-1:0]       rd_fmt;
    logic [ADDR_W*NUM_RD-1:0]  rd_addr;
    logic [2*REG_W*NUM_RD-1:0] rd_data;
    logic [NUM_RD-1:0]         rd_busy;
    logic                      wr_en;
    logic [4:0]                wr_fmt;
    logic [ADDR_W-1:0]         wr_addr;
    logic [2*REG_W-1:0]        wr_data;
    logic                      rsv_en;
    logic [4:0]                rsv_fmt;
    logic [ADDR_W-1:0]         rsv_addr;
    logic                      fmt_err;

    modport master (
        output rd_fmt, rd_addr, wr_en, wr_fmt, wr_addr, wr_data, rsv_en, rsv_fmt, rsv_addr,
        input  rd_data, rd_busy, fmt_err
    );

    modport slave (
        input  rd_fmt, rd_addr, wr_en, wr_fmt, wr_addr, wr_data, rsv_en, rsv_fmt, rsv_addr,
        output rd_data, rd_busy, fmt_err
    );

endinterface

// File: rtl/fp_rf_scoreboard.sv
// Pending-write bit per FP register: set on reserve, cleared on write-back, set wins on collision.
// Busy lookup is combinational (pre-update state); FP_RF_BYPASS_EN lets a same-cycle write hide its bit.
module fp_rf_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_rsv_vld,
    input  logic                     i_rsv_dbl,
    input  logic [ADDR_W-1:0]        i_rsv_addr,
    input  logic                     i_clr_vld,
    input  logic                     i_clr_dbl,
    input  logic [ADDR_W-1:0]        i_clr_addr,
    input  logic [ADDR_W*NUM_RD-1:0] i_rd_addr,
    input  logic [NUM_RD-1:0]        i_rd_dbl,
    output logic [NUM_RD-1:0]        o_rd_busy
);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_look;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_rsv_vld) begin
            w_set[i_rsv_addr] = 1'b1;
            if (i_rsv_dbl) w_set[i_rsv_addr + ONE] = 1'b1;
        end
        if (i_clr_vld) begin
            w_clr[i_clr_addr] = 1'b1;
            if (i_clr_dbl) w_clr[i_clr_addr + ONE] = 1'b1;
        end
    end

`ifdef FP_RF_BYPASS_EN
    // A forwarded register only stays busy if a new producer claims it this cycle.
    assign w_look = (r_pend & ~w_clr) | (w_clr & w_set);
`else
    assign w_look = r_pend;
`endif

    always_comb begin
        o_rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            o_rd_busy[p] = w_look[i_rd_addr[p*ADDR_W +: ADDR_W]]
                         | (i_rd_dbl[p] & w_look[i_rd_addr[p*ADDR_W +: ADDR_W] | ONE]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_pend <= '0;
        else     r_pend <= (r_pend & ~w_clr) | w_set;
    end

endmodule

// File: rtl/fp_regfile_mp.sv
// FP register file, NUM_RD registered read ports (1-cycle latency), S/D operands on even/odd pairs, scoreboard.
// Always ready, no backpressure; FP_RF_BYPASS_EN forwards same-cycle WB data and busy into the read ports.
module fp_regfile_mp
    import fp_rf_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int REG_W     = 32,
    parameter int NUM_RD    = 2,
    parameter int ZERO_LOCK = 1
) (
    input  logic           clk,
    input  logic           rst,
    fp_regfile_mp_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [REG_W-1:0]          r_regs  [NUM_REGS];
    logic [REG_W-1:0]          w_wval  [NUM_REGS];
    logic [REG_W-1:0]          w_rview [NUM_REGS];
    logic [NUM_REGS-1:0]       w_we;
    logic [ADDR_W-1:0]         w_ra    [NUM_RD];
    rd_port_t                  w_rd_dec [NUM_RD];
    logic [NUM_RD-1:0]         w_rd_dbl;
    logic [NUM_RD-1:0]         w_rd_busy;
    rd_port_t                  w_wr_dec;
    rd_port_t                  w_rsv_dec;
    logic                      w_wr_do;
    logic                      w_clr_vld;
    logic                      w_rd_ill;
    logic                      w_err;
    logic [2*REG_W*NUM_RD-1:0] w_rd_nxt;
    logic [2*REG_W*NUM_RD-1:0] r_rd_data;
    logic [NUM_RD-1:0]         r_rd_busy;
    logic                      r_fmt_err;

    assign w_wr_dec  = fmt_decode(bus.wr_fmt, bus.wr_addr[0]);
    assign w_rsv_dec = fmt_decode(bus.rsv_fmt, bus.rsv_addr[0]);
    assign w_wr_do   = bus.wr_en && w_wr_dec.legal && !((ZERO_LOCK != 0) && (bus.wr_addr == '0));
    // A zero-locked write still retires its producer, so the clear ignores the lock.
    assign w_clr_vld = bus.wr_en && ((bus.wr_fmt == FMT_S) || (bus.wr_fmt == FMT_D));

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_we[i]   = 1'b0;
            w_wval[i] = bus.wr_data[REG_W-1:0];
            if (w_wr_do) begin
                if (ADDR_W'(i) == bus.wr_addr) begin
                    w_we[i] = 1'b1;
                end else if (w_wr_dec.dbl && (ADDR_W'(i) == (bus.wr_addr | ONE))) begin
                    w_we[i]   = 1'b1;
                    w_wval[i] = bus.wr_data[2*REG_W-1:REG_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst)          r_regs[i] <= REG_W'(i);
            else if (w_we[i]) r_regs[i] <= w_wval[i];
        end
    end

`ifdef FP_RF_BYPASS_EN
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) w_rview[i] = w_we[i] ? w_wval[i] : r_regs[i];
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) w_rview[i] = r_regs[i];
    end
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_dec
        assign w_ra[p]     = bus.rd_addr[p*ADDR_W +: ADDR_W];
        assign w_rd_dec[p] = fmt_decode(bus.rd_fmt[p*5 +: 5], w_ra[p][0]);
        assign w_rd_dbl[p] = w_rd_dec[p].dbl;
    end

    always_comb begin
        w_rd_nxt = '0;
        w_rd_ill = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (!w_rd_dec[p].legal) begin
                w_rd_ill = 1'b1;
            end else if (w_rd_dec[p].dbl) begin
                w_rd_nxt[p*2*REG_W +: 2*REG_W] = {w_rview[w_ra[p] | ONE], w_rview[w_ra[p]]};
            end else begin
                w_rd_nxt[p*2*REG_W +: REG_W] = w_rview[w_ra[p]];
            end
        end
    end

    assign w_err = w_rd_ill
                 | (bus.wr_en  & ~w_wr_dec.legal)
                 | (bus.rsv_en & ~w_rsv_dec.legal);

    fp_rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_rsv_vld  (bus.rsv_en & w_rsv_dec.legal),
        .i_rsv_dbl  (w_rsv_dec.dbl),
        .i_rsv_addr (bus.rsv_addr),
        .i_clr_vld  (w_clr_vld),
        .i_clr_dbl  (w_wr_dec.dbl),
        .i_clr_addr (bus.wr_addr),
        .i_rd_addr  (bus.rd_addr),
        .i_rd_dbl   (w_rd_dbl),
        .o_rd_busy  (w_rd_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_rd_busy <= '0;
            r_fmt_err <= 1'b0;
        end else begin
            r_rd_data <= w_rd_nxt;
            r_rd_busy <= w_rd_busy;
            r_fmt_err <= w_err;
        end
    end

    assign bus.rd_data = r_rd_data;
    assign bus.rd_busy = r_rd_busy;
    assign bus.fmt_err = r_fmt_err;

endmodule

// File: tb/tb_fp_regfile_mp.sv
// Bench for fp_regfile_mp: vector table plus hand-written same-cycle sequences, two DUTs (ZERO_LOCK 1 and 0).
module tb_fp_regfile_mp;

    localparam logic [4:0] S = 5'h10;
    localparam logic [4:0] D = 5'h11;

    typedef struct {
        logic        rst;
        logic        wr_en;
        logic [4:0]  wr_fmt;
        logic [4:0]  wr_addr;
        logic [63:0] wr_data;
        logic        rsv_en;
        logic [4:0]  rsv_fmt;
        logic [4:0]  rsv_addr;
        logic [4:0]  f0;
        logic [4:0]  a0;
        logic [4:0]  f1;
        logic [4:0]  a1;
        logic [63:0] e0;
        logic [63:0] e1;
        logic [1:0]  eb;
        logic        ee;
        logic        chk_zl;
        logic [63:0] ezl;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];
    vec_t expq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fp_regfile_mp_if #(.NUM_REGS(32), .REG_W(32), .NUM_RD(2)) bus ();
    fp_regfile_mp_if #(.NUM_REGS(32), .REG_W(32), .NUM_RD(2)) bus_z ();

    fp_regfile_mp #(.NUM_REGS(32), .REG_W(32), .NUM_RD(2), .ZERO_LOCK(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fp_regfile_mp #(.NUM_REGS(32), .REG_W(32), .NUM_RD(2), .ZERO_LOCK(0)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z)
    );

    assign bus_z.rd_fmt   = bus.rd_fmt;
    assign bus_z.rd_addr  = bus.rd_addr;
    assign bus_z.wr_en    = bus.wr_en;
    assign bus_z.wr_fmt   = bus.wr_fmt;
    assign bus_z.wr_addr  = bus.wr_addr;
    assign bus_z.wr_data  = bus.wr_data;
    assign bus_z.rsv_en   = bus.rsv_en;
    assign bus_z.rsv_fmt  = bus.rsv_fmt;
    assign bus_z.rsv_addr = bus.rsv_addr;

    function automatic vec_t rdv(input logic [4:0] f0, input logic [4:0] a0,
                                 input logic [4:0] f1, input logic [4:0] a1,
                                 input logic [63:0] e0, input logic [63:0] e1,
                                 input logic [1:0] eb, input logic ee);
        vec_t v;
        v.rst = 1'b0; v.wr_en = 1'b0; v.wr_fmt = S; v.wr_addr = '0; v.wr_data = '0;
        v.rsv_en = 1'b0; v.rsv_fmt = S; v.rsv_addr = '0;
        v.f0 = f0; v.a0 = a0; v.f1 = f1; v.a1 = a1;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ee = ee;
        v.chk_zl = 1'b0; v.ezl = '0;
        return v;
    endfunction

    function automatic vec_t wr(input vec_t vi, input logic [4:0] f, input logic [4:0] a, input logic [63:0] d);
        vec_t v = vi;
        v.wr_en = 1'b1; v.wr_fmt = f; v.wr_addr = a; v.wr_data = d;
        return v;
    endfunction

    function automatic vec_t rsv(input vec_t vi, input logic [4:0] f, input logic [4:0] a);
        vec_t v = vi;
        v.rsv_en = 1'b1; v.rsv_fmt = f; v.rsv_addr = a;
        return v;
    endfunction

    function automatic vec_t zl(input vec_t vi, input logic [63:0] e);
        vec_t v = vi;
        v.chk_zl = 1'b1; v.ezl = e;
        return v;
    endfunction

    function automatic vec_t rs(input vec_t vi);
        vec_t v = vi;
        v.rst = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        rst          = v.rst;
        bus.wr_en    = v.wr_en;
        bus.wr_fmt   = v.wr_fmt;
        bus.wr_addr  = v.wr_addr;
        bus.wr_data  = v.wr_data;
        bus.rsv_en   = v.rsv_en;
        bus.rsv_fmt  = v.rsv_fmt;
        bus.rsv_addr = v.rsv_addr;
        bus.rd_fmt   = {v.f1, v.f0};
        bus.rd_addr  = {v.a1, v.a0};
        expq.push_back(v);
        @(posedge clk);
        #1;
        e = expq.pop_front();
        check(tag, "rd_data0", bus.rd_data[63:0], e.e0);
        check(tag, "rd_data1", bus.rd_data[127:64], e.e1);
        check(tag, "rd_busy", {62'd0, bus.rd_busy}, {62'd0, e.eb});
        check(tag, "fmt_err", {63'd0, bus.fmt_err}, {63'd0, e.ee});
        if (e.chk_zl) check(tag, "zl0_rd_data0", bus_z.rd_data[63:0], e.ezl);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_fmt = S; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rsv_en = 1'b0; bus.rsv_fmt = S; bus.rsv_addr = '0;
        bus.rd_fmt = {S, S}; bus.rd_addr = '0;

        tbl.push_back(rs(rdv(S, 5, S, 0, 64'h0, 64'h0, 2'b00, 1'b0)));
        tbl.push_back(zl(rdv(S, 5, D, 2, 64'h5, 64'h0000_0003_0000_0002, 2'b00, 1'b0), 64'h5));
        tbl.push_back(wr(rdv(S, 1, S, 6, 64'h1, 64'h6, 2'b00, 1'b0), D, 4, 64'hAAAA_BBBB_CCCC_DDDD));
        tbl.push_back(rdv(S, 5, D, 4, 64'h0000_0000_AAAA_BBBB, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 1'b0));
        tbl.push_back(wr(rdv(S, 3, S, 7, 64'h3, 64'h7, 2'b00, 1'b1), D, 3, 64'h1111_1111_2222_2222));
        tbl.push_back(rdv(D, 2, S, 4, 64'h0000_0003_0000_0002, 64'h0000_0000_CCCC_DDDD, 2'b00, 1'b0));
        tbl.push_back(rdv(D, 7, S, 1, 64'h0, 64'h1, 2'b00, 1'b1));
        tbl.push_back(rdv(S, 7, S, 0, 64'h7, 64'h0, 2'b00, 1'b0));
        tbl.push_back(zl(wr(rdv(S, 1, S, 9, 64'h1, 64'h9, 2'b00, 1'b0), S, 0, 64'hDEAD), 64'h1));
        tbl.push_back(zl(rdv(S, 0, S, 2, 64'h0, 64'h2, 2'b00, 1'b0), 64'hDEAD));
        tbl.push_back(rsv(rdv(S, 9, S, 8, 64'h9, 64'h8, 2'b00, 1'b0), D, 8));
        tbl.push_back(rdv(S, 9, D, 8, 64'h9, 64'h0000_0009_0000_0008, 2'b11, 1'b0));
        tbl.push_back(wr(rdv(S, 10, S, 3, 64'hA, 64'h3, 2'b00, 1'b0), D, 8, 64'h0000_0099_0000_0088));
        tbl.push_back(rdv(S, 9, D, 8, 64'h99, 64'h0000_0099_0000_0088, 2'b00, 1'b0));
        tbl.push_back(rsv(wr(rdv(S, 5, S, 6, 64'hAAAA_BBBB, 64'h6, 2'b00, 1'b0), S, 8, 64'h77), S, 8));
        tbl.push_back(rdv(S, 8, S, 9, 64'h77, 64'h99, 2'b01, 1'b0));
        tbl.push_back(rsv(rdv(S, 10, S, 11, 64'hA, 64'hB, 2'b00, 1'b1), 5'h12, 10));
        tbl.push_back(rdv(S, 10, S, 11, 64'hA, 64'hB, 2'b00, 1'b0));
        tbl.push_back(rdv(S, 12, 5'h14, 13, 64'hC, 64'h0, 2'b00, 1'b1));
        tbl.push_back(rs(rsv(wr(rdv(S, 5, S, 6, 64'h0, 64'h0, 2'b00, 1'b0), S, 5, 64'h55), S, 6)));
        tbl.push_back(rdv(S, 5, S, 8, 64'h5, 64'h8, 2'b00, 1'b0));
        tbl.push_back(rdv(S, 6, D, 4, 64'h6, 64'h0000_0005_0000_0004, 2'b00, 1'b0));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("row%0d", i));

        // Same-cycle write/read of f2, first against a pending producer, then with a re-reserve.
        run_vec(rsv(rdv(S, 2, S, 3, 64'h2, 64'h3, 2'b00, 1'b0), S, 2), "byp_rsv");
`ifdef FP_RF_BYPASS_EN
        run_vec(wr(rdv(S, 2, D, 2, 64'h1234, 64'h0000_0003_0000_1234, 2'b00, 1'b0), S, 2, 64'h1234), "byp_hit");
`else
        run_vec(wr(rdv(S, 2, D, 2, 64'h2, 64'h0000_0003_0000_0002, 2'b11, 1'b0), S, 2, 64'h1234), "byp_hit");
`endif
        run_vec(rdv(S, 2, D, 2, 64'h1234, 64'h0000_0003_0000_1234, 2'b00, 1'b0), "byp_after");
`ifdef FP_RF_BYPASS_EN
        run_vec(rsv(wr(rdv(S, 2, S, 3, 64'h5678, 64'h3, 2'b01, 1'b0), S, 2, 64'h5678), S, 2), "byp_rersv");
`else
        run_vec(rsv(wr(rdv(S, 2, S, 3, 64'h1234, 64'h3, 2'b00, 1'b0), S, 2, 64'h5678), S, 2), "byp_rersv");
`endif
        run_vec(rdv(S, 2, S, 3, 64'h5678, 64'h3, 2'b01, 1'b0), "byp_rersv_after");

        // Odd D reserve: one-cycle fmt_err, no pending bits left behind.
        run_vec(rsv(rdv(S, 13, S, 12, 64'hD, 64'hC, 2'b00, 1'b1), D, 13), "rsv_odd");
        run_vec(rdv(S, 13, S, 14, 64'hD, 64'hE, 2'b00, 1'b0), "rsv_odd_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
